ps2_key_decoder: RTL and testbench

Sits between the PS/2 controller and blackjack_fsm. It parses the Set-2 scancode byte stream (received_data / received_data_en), tracking make, break and extended prefixes. For each new press of the H, S or D key it emits exactly one single-cycle pulse on hit_pressed, stand_pressed or deal_pressed. Typematic auto-repeat is suppressed, so a held key produces one pulse.

---
 rtl/blackjack_pkg.sv | 56 +++++
 rtl/ps2_prefix_timer.sv | 34 +++
 rtl/ps2_key_decoder.sv | 148 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blackjack_pkg.sv
// Shared scancodes, parser state encoding and key indices for the blackjack keyboard path.
// Latency: none (declarations and pure functions only).
// Backpressure: none; PS/2 bytes cannot be stalled.
package blackjack_pkg;

    // Set-2 scancodes used by the game
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_KPENT = 8'h5A;

    // Bit positions in key_held and in the pulse vector
    localparam int KEY_HIT   = 0;
    localparam int KEY_STAND = 1;
    localparam int KEY_DEAL  = 2;
    localparam int NUM_KEYS  = 3;

    // Parser position within a multi-byte scancode sequence
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_t;

    // One-hot game key for a plain (non-extended) scancode, zero if not a game key
    function automatic logic [NUM_KEYS-1:0] std_key_mask(input logic [7:0] code);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        case (code)
            SC_H:    mask[KEY_HIT]   = 1'b1;
            SC_S:    mask[KEY_STAND] = 1'b1;
            SC_D:    mask[KEY_DEAL]  = 1'b1;
            default: mask = '0;
        endcase
        return mask;
    endfunction

    // One-hot game key for an E0-prefixed scancode (arrow / keypad aliases)
    function automatic logic [NUM_KEYS-1:0] ext_key_mask(input logic [7:0] code);
        logic [NUM_KEYS-1:0] mask;
        mask = '0;
        case (code)
            SC_UP:    mask[KEY_HIT]   = 1'b1;
            SC_DOWN:  mask[KEY_STAND] = 1'b1;
            SC_KPENT: mask[KEY_DEAL]  = 1'b1;
            default:  mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Saturating counter that measures how long the parser has waited for the byte after a prefix.
// Latency: o_expired is combinational from the count; count updates one cycle after i_en.
// Backpressure: none; i_clr has priority over i_en, the count never wraps.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count waiting cycles; clear on any accepted byte or while idle, hold at the top value
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry only matters while the counter is actually running
    assign o_expired = i_en && (r_cnt >= CNT_LAST);

endmodule

// File: rtl/ps2_key_decoder.sv
// Parses PS/2 Set-2 make/break/extended bytes into one-shot H/S/D press pulses plus held-key levels.
// Latency: pulses, key_held and seq_error update 1 cycle after the byte strobe (registered outputs).
// Backpressure: none; a byte is accepted on every received_data_en, back-to-back included.
// Optional: define EXT_ARROWS_EN to alias Up/Down/keypad-Enter onto H/S/D.
module ps2_key_decoder
    import blackjack_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       hit_pressed,
    output logic       stand_pressed,
    output logic       deal_pressed,
    output logic [2:0] key_held,
    output logic       seq_error
);

    parse_state_t        r_state;
    parse_state_t        w_next_state;
    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] r_pulse;
    logic                r_err;

    logic [NUM_KEYS-1:0] w_held_nxt;
    logic [NUM_KEYS-1:0] w_pulse_nxt;
    logic                w_err_nxt;
    logic                w_is_prefix;
    logic                w_dup;
    logic                w_restart;
    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic                w_expired;
    logic [NUM_KEYS-1:0] w_std_mask;
    logic [NUM_KEYS-1:0] w_ext_mask;

    assign w_std_mask = std_key_mask(received_data);
`ifdef EXT_ARROWS_EN
    assign w_ext_mask = ext_key_mask(received_data);
`else
    assign w_ext_mask = '0;
`endif

    // A prefix arriving mid-sequence is an error, except F0 directly after E0
    assign w_is_prefix = (received_data == SC_EXT) || (received_data == SC_BRK);
    assign w_dup       = received_data_en && (r_state != ST_IDLE) && w_is_prefix
                         && !((r_state == ST_EXT) && (received_data == SC_BRK));
    // Bytes seen from IDLE, and the offending prefix after a duplicate, both start a fresh sequence
    assign w_restart   = (r_state == ST_IDLE) || w_dup;

    // The timer only runs while waiting for a follow-up byte
    assign w_tmr_clr = received_data_en || (r_state == ST_IDLE);
    assign w_tmr_en  = (r_state != ST_IDLE) && !received_data_en;

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_prefix_timer (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    // Parser state register
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next parser state from the current byte, or back to IDLE on timeout
    always_comb begin
        w_next_state = r_state;
        if (received_data_en) begin
            if (w_restart) begin
                if (received_data == SC_EXT) begin
                    w_next_state = ST_EXT;
                end else if (received_data == SC_BRK) begin
                    w_next_state = ST_BRK;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end else if ((r_state == ST_EXT) && (received_data == SC_BRK)) begin
                w_next_state = ST_EXT_BRK;
            end else begin
                w_next_state = ST_IDLE;
            end
        end else if (w_expired) begin
            w_next_state = ST_IDLE;
        end
    end

    // Held-key update, press pulses (suppressing typematic repeats) and sequence errors
    always_comb begin
        w_held_nxt  = r_held;
        w_pulse_nxt = '0;
        w_err_nxt   = w_dup || (!received_data_en && w_expired);
        if (received_data_en) begin
            if (w_restart) begin
                w_pulse_nxt = w_std_mask & ~r_held;
                w_held_nxt  = r_held | w_std_mask;
            end else begin
                case (r_state)
                    ST_BRK: begin
                        w_held_nxt = r_held & ~w_std_mask;
                    end
                    ST_EXT: begin
                        if (received_data != SC_BRK) begin
                            w_pulse_nxt = w_ext_mask & ~r_held;
                            w_held_nxt  = r_held | w_ext_mask;
                        end
                    end
                    ST_EXT_BRK: begin
                        w_held_nxt = r_held & ~w_ext_mask;
                    end
                    default: begin
                        w_held_nxt = r_held;
                    end
                endcase
            end
        end
    end

    // Register all outputs so pulses are glitch-free single-cycle strobes
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_held  <= '0;
            r_pulse <= '0;
            r_err   <= 1'b0;
        end else begin
            r_held  <= w_held_nxt;
            r_pulse <= w_pulse_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign hit_pressed   = r_pulse[KEY_HIT];
    assign stand_pressed = r_pulse[KEY_STAND];
    assign deal_pressed  = r_pulse[KEY_DEAL];
    assign key_held      = r_held;
    assign seq_error     = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int TB_T = 20;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       hit_pressed, stand_pressed, deal_pressed, seq_error;
    logic [2:0] key_held;

    int errors = 0;
    int checks = 0;
    int n_hit = 0, n_stand = 0, n_deal = 0, n_err = 0;
    bit run = 1'b1;

    always #10 CLOCK_50 = ~CLOCK_50;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TB_T)) dut (
        .CLOCK_50         (CLOCK_50),
        .rst_n            (rst_n),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .hit_pressed      (hit_pressed),
        .stand_pressed    (stand_pressed),
        .deal_pressed     (deal_pressed),
        .key_held         (key_held),
        .seq_error        (seq_error)
    );

    // Reference model: pending prefix flags, idle-wait count and expected outputs
    typedef struct packed {
        logic       ext;
        logic       brk;
        int         idle;
        logic [2:0] held;
        logic [2:0] pulse;
        logic       err;
    } mdl_t;

    mdl_t m = '0;

    function automatic int game_key(input logic [7:0] b, input bit extended);
        if (!extended) begin
            if (b == 8'h33) return 0;
            if (b == 8'h1B) return 1;
            if (b == 8'h23) return 2;
        end else begin
`ifdef EXT_ARROWS_EN
            if (b == 8'h75) return 0;
            if (b == 8'h72) return 1;
            if (b == 8'h5A) return 2;
`endif
        end
        return -1;
    endfunction

    function automatic mdl_t model_step(input mdl_t s, input logic v, input logic [7:0] b);
        mdl_t n;
        bit   pending, prefix, legal, fresh;
        int   k;
        n = s;
        n.pulse = '0;
        n.err = 1'b0;
        pending = s.ext || s.brk;
        if (v) begin
            n.idle = 0;
            prefix = (b == 8'hE0) || (b == 8'hF0);
            legal = s.ext && !s.brk && (b == 8'hF0);
            fresh = !pending;
            if (pending && prefix && !legal) begin
                n.err = 1'b1;
                fresh = 1'b1;
            end
            if (fresh) begin
                n.ext = (b == 8'hE0);
                n.brk = (b == 8'hF0);
                k = game_key(b, 1'b0);
                if (k >= 0) begin
                    if (!s.held[k]) n.pulse[k] = 1'b1;
                    n.held[k] = 1'b1;
                end
            end else if (s.ext && !s.brk) begin
                if (b == 8'hF0) begin
                    n.brk = 1'b1;
                end else begin
                    n.ext = 1'b0;
                    k = game_key(b, 1'b1);
                    if (k >= 0) begin
                        if (!s.held[k]) n.pulse[k] = 1'b1;
                        n.held[k] = 1'b1;
                    end
                end
            end else begin
                k = game_key(b, s.ext);
                if (k >= 0) n.held[k] = 1'b0;
                n.ext = 1'b0;
                n.brk = 1'b0;
            end
        end else if (pending) begin
            if (s.idle == TB_T - 1) begin
                n.err = 1'b1;
                n.ext = 1'b0;
                n.brk = 1'b0;
                n.idle = 0;
            end else begin
                n.idle = s.idle + 1;
            end
        end
        return n;
    endfunction

    always @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, received_data_en, received_data);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus observed pulse tallies
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (run) begin
                check("hit_pressed",   {31'd0, hit_pressed},   {31'd0, m.pulse[0]});
                check("stand_pressed", {31'd0, stand_pressed}, {31'd0, m.pulse[1]});
                check("deal_pressed",  {31'd0, deal_pressed},  {31'd0, m.pulse[2]});
                check("key_held",      {29'd0, key_held},      {29'd0, m.held});
                check("seq_error",     {31'd0, seq_error},     {31'd0, m.err});
                if (hit_pressed)   n_hit++;
                if (stand_pressed) n_stand++;
                if (deal_pressed)  n_deal++;
                if (seq_error)     n_err++;
            end
        end
    end

    task automatic put(input logic [7:0] b);
        received_data_en = 1'b1;
        received_data = b;
        @(posedge CLOCK_50);
        #1;
        received_data_en = 1'b0;
        received_data = $urandom_range(0, 255);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        @(negedge CLOCK_50);
        #1;
        check(name, got, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random byte traffic: nothing may respond
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            received_data_en = 1'($urandom_range(0, 1));
            received_data = (i % 2 == 0) ? 8'h33 : 8'($urandom_range(0, 255));
            @(posedge CLOCK_50);
            #1;
        end
        lit("rst_held", key_held, 0);
        lit("rst_hit", hit_pressed, 0);
        received_data_en = 1'b0;
        @(posedge CLOCK_50); #1;
        rst_n = 1'b1;
        idle(2);

        // Make, typematic repeats, then break
        put(8'h33);
        @(negedge CLOCK_50);
        check("hit_latency", hit_pressed, 1);
        put(8'h33);
        put(8'h33);
        idle(2);
        lit("hit_once", n_hit, 1);
        lit("held_h", key_held, 3'b001);
        put(8'hF0);
        put(8'h33);
        idle(2);
        lit("held_h_clr", key_held, 3'b000);

        // Mixed keys
        put(8'h1B); lit("held_s", key_held, 3'b010);
        put(8'h23); lit("held_sd", key_held, 3'b110);
        put(8'hF0); put(8'h1B); lit("held_d", key_held, 3'b100);
        put(8'hF0); put(8'h23); lit("held_none", key_held, 3'b000);
        lit("mixed_stand", n_stand, 1);
        lit("mixed_deal", n_deal, 1);
        lit("mixed_hit", n_hit, 1);

        // Prefix timeout, then the next byte is a fresh make
        put(8'hF0);
        idle(TB_T - 3);
        lit("no_early_err", n_err, 0);
        idle(6);
        lit("timeout_err", n_err, 1);
        put(8'h33);
        idle(2);
        lit("post_to_hit", n_hit, 2);
        lit("post_to_held", key_held, 3'b001);
        put(8'hF0); put(8'h33);

        // Duplicate prefix restarts the sequence
        put(8'hF0); put(8'hF0); put(8'h1B);
        idle(2);
        lit("dup_err", n_err, 2);
        lit("dup_stand", n_stand, 1);
        put(8'hE0); put(8'hE0); put(8'h12);
        idle(2);
        lit("dup_ext_err", n_err, 3);

        // Extended aliases
        put(8'hE0); put(8'h75);
        idle(2);
`ifdef EXT_ARROWS_EN
        lit("ext_hit", n_hit, 3);
        lit("ext_held", key_held, 3'b001);
`else
        lit("ext_hit", n_hit, 2);
        lit("ext_held", key_held, 3'b000);
`endif
        put(8'hE0); put(8'hF0); put(8'h75);
        idle(2);
        lit("ext_clr", key_held, 3'b000);

        // Back-to-back bytes
        put(8'h1B); put(8'hF0); put(8'h1B);
        idle(2);
        lit("b2b_stand", n_stand, 2);
        lit("b2b_held", key_held, 3'b000);

        // Reset while waiting after a break prefix
        put(8'hF0);
        rst_n = 1'b0;
        idle(2);
        lit("rst_brk_held", key_held, 3'b000);
        rst_n = 1'b1;
        idle(1);
        put(8'h1B);
        idle(2);
        lit("rst_brk_stand", n_stand, 3);
        lit("rst_brk_held2", key_held, 3'b010);

        idle(2);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
